// File: rtl/diag_event_arbiter.sv
// ----------------------------------------------------------------------------
// diag_event_arbiter
//   Shares the single debug-output flit stream between NUM_SRC diagnosis
//   event-packet generators. Round-robin arbitration at packet granularity:
//   one IDLE cycle per packet to pick a source, the grant is held until that
//   source's last flit. Packets longer than MAX_PKT_LEN are cut (the last
//   forwarded flit is marked last) and the remainder is drained and dropped.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   src_valid/last/data per-source flit stream (16 bits per source)
//   src_ready           per-source ready, only the granted source can see 1
//   src_en              per-source enable mask, sampled when arbitrating
//   out_valid/last/data merged flit stream toward regaccess (combinational
//                       from the granted source)
//   out_ready           downstream ready
//   pkt_cnt             forwarded packets, saturating
//   ovf_cnt             truncated packets, saturating
//   busy                high whenever a packet is granted or being drained
// ----------------------------------------------------------------------------
module diag_event_arbiter #(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned MAX_PKT_LEN = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SRC-1:0]    src_valid,
   input  logic [NUM_SRC-1:0]    src_last,
   input  logic [16*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]    src_ready,
   input  logic [NUM_SRC-1:0]    src_en,
   output logic                  out_valid,
   output logic                  out_last,
   output logic [15:0]           out_data,
   input  logic                  out_ready,
   output logic [15:0]           pkt_cnt,
   output logic [15:0]           ovf_cnt,
   output logic                  busy
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned STAT_W = 16;
   localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned SUM_W  = IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant;
   logic [CNT_W-1:0]   flit_cnt;

   logic [DATA_W-1:0]  data_arr [NUM_SRC];
   logic [NUM_SRC-1:0] req;
   logic [IDX_W-1:0]   sel;
   logic               sel_found;
   logic               g_valid;
   logic               g_last;
   logic [DATA_W-1:0]  g_data;
   logic               at_max;
   logic               xfer;

   // (a + b) mod NUM_SRC for a, b < NUM_SRC
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + SUM_W'(b);
      if (sum >= SUM_W'(NUM_SRC)) begin
         sum = sum - SUM_W'(NUM_SRC);
      end
      return IDX_W'(sum);
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

   // Unpack the flat per-source data bus
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign data_arr[i] = src_data[DATA_W*i +: DATA_W];
   end

   assign req = src_valid & src_en;

   // First requester at or after rr_ptr, wrapping
   always_comb begin
      sel       = rr_ptr;
      sel_found = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (!sel_found && req[wrap_add(rr_ptr, IDX_W'(k))]) begin
            sel_found = 1'b1;
            sel       = wrap_add(rr_ptr, IDX_W'(k));
         end
      end
   end

   // Granted source view
   assign g_valid = src_valid[grant];
   assign g_last  = src_last[grant];
   assign g_data  = data_arr[grant];
   assign at_max  = (flit_cnt == CNT_W'(MAX_PKT_LEN - 1));

   // Handshake on the granted source: downstream-paced in GRANT, always
   // accepted in DRAIN
   always_comb begin
      xfer = 1'b0;
      case (state)
         GRANT:   xfer = g_valid & out_ready;
         DRAIN:   xfer = g_valid;
         default: xfer = 1'b0;
      endcase
   end

   // Flit-path outputs, combinational from the granted source
   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      src_ready = '0;
      case (state)
         GRANT: begin
            out_valid        = g_valid;
            out_data         = g_data;
            // Truncation point forces last so downstream sees a closed packet
            out_last         = g_last | at_max;
            src_ready[grant] = out_ready;
         end
         DRAIN: begin
            src_ready[grant] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign busy = (state != IDLE);

   // Arbitration state, packet bookkeeping and statistics
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         flit_cnt <= '0;
         pkt_cnt  <= '0;
         ovf_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  grant <= sel;
                  state <= GRANT;
               end
            end

            GRANT: begin
               if (xfer) begin
                  if (g_last) begin
                     state    <= IDLE;
                     rr_ptr   <= wrap_add(grant, IDX_W'(1));
                     flit_cnt <= '0;
                     pkt_cnt  <= sat_inc(pkt_cnt);
                  end else if (at_max) begin
                     state    <= DRAIN;
                     flit_cnt <= flit_cnt + CNT_W'(1);
                     pkt_cnt  <= sat_inc(pkt_cnt);
                     ovf_cnt  <= sat_inc(ovf_cnt);
                  end else begin
                     flit_cnt <= flit_cnt + CNT_W'(1);
                  end
               end
            end

            DRAIN: begin
               if (xfer && g_last) begin
                  state    <= IDLE;
                  rr_ptr   <= wrap_add(grant, IDX_W'(1));
                  flit_cnt <= '0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diag_event_arbiter.sv
// ----------------------------------------------------------------------------
// tb_diag_event_arbiter
//   Directed bench for diag_event_arbiter (NUM_SRC=4, MAX_PKT_LEN=8).
//   Per-source flit queues feed the DUT; expected output flits are pushed to
//   a scoreboard when the stimulus is queued and popped on each output
//   transfer. Inputs change 1 time unit after the rising edge; outputs are
//   sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_diag_event_arbiter;

   localparam int unsigned NS = 4;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } flit_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [NS-1:0]   src_valid;
   logic [NS-1:0]   src_last;
   logic [16*NS-1:0] src_data;
   logic [NS-1:0]   src_ready;
   logic [NS-1:0]   src_en;
   logic            out_valid;
   logic            out_last;
   logic [15:0]     out_data;
   logic            out_ready;
   logic [15:0]     pkt_cnt;
   logic [15:0]     ovf_cnt;
   logic            busy;

   flit_t           src_q [NS][$];
   flit_t           sb [$];
   logic [NS-1:0]   gap;

   logic            snap_out_valid;
   logic            snap_busy;
   logic [NS-1:0]   snap_ready;

   int              checks = 0;
   int              errors = 0;

   diag_event_arbiter #(.NUM_SRC(4), .MAX_PKT_LEN(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_last  (src_last),
      .src_data  (src_data),
      .src_ready (src_ready),
      .src_en    (src_en),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_ready (out_ready),
      .pkt_cnt   (pkt_cnt),
      .ovf_cnt   (ovf_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present the head flit of every source queue
   task automatic drive();
      for (int s = 0; s < NS; s++) begin
         if (src_q[s].size() > 0 && !gap[s]) begin
            src_valid[s]          = 1'b1;
            src_last[s]           = src_q[s][0].last;
            src_data[16*s +: 16]  = src_q[s][0].data;
         end else begin
            src_valid[s]          = 1'b0;
            src_last[s]           = 1'b0;
            src_data[16*s +: 16]  = 16'h0;
         end
      end
   endtask

   task automatic push_pkt(input int s, input logic [15:0] base, input int len);
      flit_t f;
      for (int i = 0; i < len; i++) begin
         f.data = base + 16'(i);
         f.last = (i == len - 1);
         src_q[s].push_back(f);
      end
   endtask

   task automatic expect_flits(input logic [15:0] base, input int len, input int last_at);
      flit_t f;
      for (int i = 0; i < len; i++) begin
         f.data = base + 16'(i);
         f.last = (i == last_at - 1);
         sb.push_back(f);
      end
   endtask

   // One clock cycle: sample at falling edge, advance sources after rising edge
   task automatic step();
      logic [NS-1:0] acc;
      flit_t         e;
      @(negedge clk);
      acc            = src_valid & src_ready;
      snap_out_valid = out_valid;
      snap_busy      = busy;
      snap_ready     = src_ready;
      check("ready_onehot", 32'($countones(src_ready) <= 1), 32'd1);
      if (out_valid && out_ready) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_last", 32'(out_last), 32'(e.last));
         end
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
         if (acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
      end
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int s = 0; s < NS; s++) src_q[s].delete();
      sb.delete();
      drive();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      src_en    = '0;
      out_ready = 1'b1;
      gap       = '0;
      src_valid = '0;
      src_last  = '0;
      src_data  = '0;
      #3;

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_src_ready", 32'(src_ready), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_pkt_cnt",   32'(pkt_cnt),   32'd0);
      check("rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single source, 3-flit packet
      src_en = 4'b0001;
      push_pkt(0, 16'h1000, 3);
      expect_flits(16'h1000, 3, 3);
      drive();
      step();
      check("single_arb_valid", 32'(snap_out_valid), 32'd0);
      check("single_arb_busy",  32'(snap_busy),      32'd0);
      step();
      check("single_first_valid", 32'(snap_out_valid), 32'd1);
      check("single_first_busy",  32'(snap_busy),      32'd1);
      step();
      step();
      check("single_idle", 32'(busy), 32'd0);
      check("single_pkt_cnt", 32'(pkt_cnt), 32'd1);
      check("single_sb_empty", 32'(sb.size()), 32'd0);

      // rr_ptr now 1: src 1 beats src 0; single-flit packets
      src_en = 4'b0011;
      push_pkt(0, 16'h2000, 1);
      push_pkt(1, 16'h2100, 1);
      expect_flits(16'h2100, 1, 1);
      expect_flits(16'h2000, 1, 1);
      drive();
      for (int i = 0; i < 4; i++) step();
      check("rr1_sb_empty", 32'(sb.size()), 32'd0);
      check("rr1_pkt_cnt", 32'(pkt_cnt), 32'd3);

      // Reset mid-packet: src 3 five flits, reset after the 2nd transfer
      src_en = 4'b1111;
      push_pkt(3, 16'h3000, 5);
      expect_flits(16'h3000, 2, 0);
      drive();
      step();
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_src_ready", 32'(src_ready), 32'd0);
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_sb_empty",  32'(sb.size()), 32'd0);
      for (int s = 0; s < NS; s++) src_q[s].delete();
      drive();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      check("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      push_pkt(0, 16'h4000, 2);
      push_pkt(2, 16'h4200, 2);
      expect_flits(16'h4000, 2, 2);
      expect_flits(16'h4200, 2, 2);
      drive();
      for (int i = 0; i < 6; i++) step();
      check("postrst_sb_empty", 32'(sb.size()), 32'd0);
      check("postrst_pkt_cnt", 32'(pkt_cnt), 32'd2);

      // Round robin: all four sources, grant order 0,1,2,3,0
      do_reset();
      src_en = 4'b1111;
      push_pkt(0, 16'h5000, 2);
      push_pkt(1, 16'h5100, 2);
      push_pkt(2, 16'h5200, 2);
      push_pkt(3, 16'h5300, 2);
      push_pkt(0, 16'h5010, 2);
      expect_flits(16'h5000, 2, 2);
      expect_flits(16'h5100, 2, 2);
      expect_flits(16'h5200, 2, 2);
      expect_flits(16'h5300, 2, 2);
      expect_flits(16'h5010, 2, 2);
      drive();
      for (int p = 0; p < 5; p++) begin
         step();
         check("rr_idle_gap", 32'(snap_out_valid), 32'd0);
         step();
         check("rr_flit0", 32'(snap_out_valid), 32'd1);
         step();
         check("rr_flit1", 32'(snap_out_valid), 32'd1);
      end
      check("rr_sb_empty", 32'(sb.size()), 32'd0);
      check("rr_pkt_cnt", 32'(pkt_cnt), 32'd5);

      // Backpressure on src 2: out_ready 1,0,1,0,...
      push_pkt(2, 16'h6200, 4);
      expect_flits(16'h6200, 4, 4);
      drive();
      step();
      for (int i = 0; i < 8; i++) begin
         out_ready = (i % 2 == 0);
         step();
         check("bp_ready", 32'(snap_ready), (i % 2 == 0) ? 32'h4 : 32'h0);
      end
      out_ready = 1'b1;
      check("bp_idle", 32'(busy), 32'd0);
      check("bp_sb_empty", 32'(sb.size()), 32'd0);
      check("bp_pkt_cnt", 32'(pkt_cnt), 32'd6);

      // Overflow: src 1 sends 10 flits, only 8 forwarded
      push_pkt(1, 16'h7100, 10);
      expect_flits(16'h7100, 8, 8);
      drive();
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         check("ovf_fwd_valid", 32'(snap_out_valid), 32'd1);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         check("ovf_drain_valid", 32'(snap_out_valid), 32'd0);
         check("ovf_drain_ready", 32'(snap_ready), 32'h2);
         check("ovf_drain_busy",  32'(snap_busy),  32'd1);
      end
      check("ovf_idle", 32'(busy), 32'd0);
      check("ovf_src_empty", 32'(src_q[1].size()), 32'd0);
      check("ovf_sb_empty", 32'(sb.size()), 32'd0);
      check("ovf_ovf_cnt", 32'(ovf_cnt), 32'd1);
      check("ovf_pkt_cnt", 32'(pkt_cnt), 32'd7);

      // Exactly MAX_PKT_LEN flits is not an overflow
      push_pkt(3, 16'h7300, 8);
      expect_flits(16'h7300, 8, 8);
      drive();
      for (int i = 0; i < 9; i++) step();
      check("max_idle", 32'(busy), 32'd0);
      check("max_sb_empty", 32'(sb.size()), 32'd0);
      check("max_ovf_cnt", 32'(ovf_cnt), 32'd1);
      check("max_pkt_cnt", 32'(pkt_cnt), 32'd8);

      // Enable mask 1010: only sources 1 and 3, alternating
      src_en = 4'b1010;
      push_pkt(0, 16'h8000, 2);
      push_pkt(2, 16'h8200, 2);
      push_pkt(1, 16'h8100, 2);
      push_pkt(1, 16'h8110, 2);
      push_pkt(3, 16'h8300, 2);
      push_pkt(3, 16'h8310, 2);
      expect_flits(16'h8100, 2, 2);
      expect_flits(16'h8300, 2, 2);
      expect_flits(16'h8110, 2, 2);
      expect_flits(16'h8310, 2, 2);
      drive();
      for (int i = 0; i < 12; i++) begin
         step();
         check("en_masked_ready", 32'(snap_ready & 4'b0101), 32'd0);
      end
      check("en_sb_empty", 32'(sb.size()), 32'd0);
      check("en_src0_held", 32'(src_q[0].size()), 32'd2);
      check("en_src2_held", 32'(src_q[2].size()), 32'd2);
      check("en_pkt_cnt", 32'(pkt_cnt), 32'd12);
      src_q[0].delete();
      src_q[2].delete();

      // Valid gap and src_en drop mid-packet: grant held, src 1 waits
      src_en = 4'b0011;
      push_pkt(0, 16'h9000, 3);
      push_pkt(1, 16'h9100, 1);
      expect_flits(16'h9000, 3, 3);
      expect_flits(16'h9100, 1, 1);
      drive();
      step();
      step();
      gap[0] = 1'b1;
      src_en = 4'b0010;
      drive();
      step();
      check("gap_valid", 32'(snap_out_valid), 32'd0);
      check("gap_ready", 32'(snap_ready), 32'h1);
      gap[0] = 1'b0;
      drive();
      for (int i = 0; i < 4; i++) step();
      check("gap_sb_empty", 32'(sb.size()), 32'd0);
      check("gap_pkt_cnt", 32'(pkt_cnt), 32'd14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/diag_event_arbiter.md
Name: diag_event_arbiter

Overview:
- Shares the single debug-output flit stream of the system diagnosis subsystem between NUM_SRC event-packet generators, e.g. trace, memory-access and snapshot packetizers.
- Performs round-robin arbitration at packet granularity and holds the grant until the source's last flit.
- Enforces a maximum packet length and keeps overflow/packet statistics for the register interface.
- Sits between the diagnosis event units and the regaccess layer's module_in port.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- MAX_PKT_LEN, 8, maximum flits per packet, including header (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- src_valid  in  NUM_SRC  per-source flit valid.
- src_last  in  NUM_SRC  per-source last-flit marker.
- src_data  in  16*NUM_SRC  per-source flit data; source i uses bits [16*i+15:16*i].
- src_ready  out  NUM_SRC  per-source ready.
- src_en  in  NUM_SRC  per-source enable mask (from config registers).
- out_valid  out  1  dii_flit valid toward regaccess.
- out_last  out  1  dii_flit last.
- out_data  out  16  dii_flit data.
- out_ready  in  1  downstream ready.
- pkt_cnt  out  16  packets forwarded, saturating at 16'hFFFF.
- ovf_cnt  out  16  truncated packets, saturating at 16'hFFFF.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE, rr_ptr=0, grant=0, flit_cnt=0;
  - pkt_cnt=0, ovf_cnt=0;
  - out_valid=0, out_last=0, out_data=0, src_ready=0, busy=0.
- A transfer occurs on any cycle with valid&&ready. The out_* signals are combinational from the granted source while in GRANT.
- IDLE:
  - Request vector is req = src_valid & src_en.
  - If req≠0, select the first set bit searching from rst_ptr upward: index rr_ptr, rr_ptr+1, ... wrapping modulo NUM_SRC.
  - Register the selection into grant and go to GRANT.
  - src_ready=0 and out_valid=0 throughout IDLE, so arbitration costs exactly one cycle per packet.
- GRANT:
  - out_valid=src_valid[grant], out_data=src_data[grant], src_ready[grant]=out_ready; all other src_ready=0.
  - Normally out_last=src_last[grant].
  - Each transfer increments flit_cnt (8-bit).
  - Transfer with src_last=1: go to IDLE, rr_ptr=(grant+1) mod NUM_SRC, flit_cnt=0, pkt_cnt+=1 (saturating).
  - Transfer with flit_cnt==MAX_PKT_LEN-1 and src_last=0: force out_last=1 on that flit, count the packet in pkt_cnt, increment ovf_cnt (saturating), go to DRAIN.
- DRAIN:
  - src_ready[grant]=1 and out_valid=0; the source's remaining flits are discarded.
  - On a transfer with src_last=1: go to IDLE, rr_ptr=(grant+1) mod NUM_SRC, flit_cnt=0.
- src_en is sampled only in IDLE. Deasserting src_en[grant] mid-packet does not abort the packet.
- A source may drop src_valid mid-packet. The grant is held, out_valid follows src_valid, and no other source is served.
- A single-flit packet (src_last on the first flit) is legal: pkt_cnt increments and the state returns to IDLE.
- Boundaries:
  - MAX_PKT_LEN flits with last on the final flit is legal and not counted as overflow.
  - rr_ptr wraps from NUM_SRC-1 to 0.
  - Simultaneous requests resolve solely by rr_ptr order.
- Reset asserted mid-packet aborts immediately. After release the module starts in IDLE with no partial flit emitted. Sources must restart their packets.

Test Plan:
- Single source: src 0 enabled and sends a 3-flit packet (data 16'h1000, 16'h1001, 16'h1002, last on the third), out_ready=1 → out carries the same 3 flits with out_last only on the third; first flit appears 1 cycle after src_valid; pkt_cnt=1, rr_ptr=1.
- Round robin: all 4 sources hold 2-flit packets continuously → grant order 0,1,2,3,0; each packet separated by one IDLE cycle.
- Backpressure: out_ready toggles 1,0,1,0 during a 4-flit packet from src 2 → src_ready[2] mirrors out_ready, no flit is lost or duplicated, other src_ready stay 0.
- Overflow: src 1 sends 10 flits, last on the 10th, with MAX_PKT_LEN=8 → 8 flits output, out_last on the 8th; flits 9–10 are accepted and dropped; ovf_cnt=1, pkt_cnt=1, state returns to IDLE after the 10th.
- Enable mask: src_en=4'b1010 with all sources valid → only sources 1 and 3 are granted, alternating; sources 0 and 2 see src_ready=0 forever.
- Reset mid-packet: assert rst=0 after the 2nd flit of a 5-flit packet → out_valid=0 and all src_ready=0 immediately (asynchronous); after release, the counters read 0 and the next grant goes to the lowest-index requester.
